// File: rtl/sprite_plotter.sv
// sprite_plotter: N-sprite erase/redraw engine driving a pixel-write port, one pixel per clock
module sprite_plotter #(
  parameter int NUM_SPRITES = 2,
  parameter int SPR_W = 2,
  parameter int SPR_H = 2,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int COL_W = 3,
  parameter logic [COL_W-1:0] BG_COLOUR = '0
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         tick,
  input  logic [NUM_SPRITES*X_W-1:0]   pos_x,
  input  logic [NUM_SPRITES*Y_W-1:0]   pos_y,
  input  logic [NUM_SPRITES*COL_W-1:0] colour,
  input  logic [NUM_SPRITES-1:0]       enable,
  output logic [X_W-1:0]               out_x,
  output logic [Y_W-1:0]               out_y,
  output logic [COL_W-1:0]             out_colour,
  output logic                         plot,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);
  localparam int IW = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1;
  localparam int DW = SPR_W > 1 ? $clog2(SPR_W) : 1;
  localparam int HW = SPR_H > 1 ? $clog2(SPR_H) : 1;
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FIN} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [DW-1:0] dx;
  logic [HW-1:0] dy;
  logic [X_W-1:0] px_s [NUM_SPRITES];
  logic [Y_W-1:0] py_s [NUM_SPRITES];
  logic [COL_W-1:0] col_s [NUM_SPRITES];
  logic [X_W-1:0] last_x [NUM_SPRITES];
  logic [Y_W-1:0] last_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] en_s, last_valid;
  logic erasing, pass, active, last_col, last_pix, last_spr, step;
  logic [X_W-1:0] base_x;
  logic [Y_W-1:0] base_y;
  always_comb begin
    erasing = state == ERASE;
    pass = state == ERASE || state == DRAW;
    base_x = erasing ? last_x[idx] : px_s[idx];
    base_y = erasing ? last_y[idx] : py_s[idx];
    active = erasing ? last_valid[idx] && (!en_s[idx] || px_s[idx] != last_x[idx] || py_s[idx] != last_y[idx])
                     : en_s[idx];
    last_col = dx == DW'(SPR_W - 1);
    last_pix = last_col && dy == HW'(SPR_H - 1);
    last_spr = idx == IW'(NUM_SPRITES - 1);
    step = !active || last_pix;
    state_nx = state == IDLE ? (tick ? ERASE : IDLE)
             : state == FIN ? IDLE
             : (step && last_spr) ? (erasing ? DRAW : FIN)
             : state;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_x <= '0;
      out_y <= '0;
      out_colour <= '0;
      plot <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
      idx <= '0;
      dx <= '0;
      dy <= '0;
      en_s <= '0;
      last_valid <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        px_s[i] <= '0;
        py_s[i] <= '0;
        col_s[i] <= '0;
        last_x[i] <= '0;
        last_y[i] <= '0;
      end
    end else begin
      done <= state == FIN;
      busy <= state == IDLE ? tick : state != FIN;
      overrun <= overrun || (tick && busy);
      plot <= pass && active;
      if (pass && active) begin
        out_x <= base_x + X_W'(dx);
        out_y <= base_y + Y_W'(dy);
        out_colour <= erasing ? BG_COLOUR : col_s[idx];
      end
      if (state == IDLE && tick) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          px_s[i] <= pos_x[i*X_W +: X_W];
          py_s[i] <= pos_y[i*Y_W +: Y_W];
          col_s[i] <= colour[i*COL_W +: COL_W];
        end
        en_s <= enable;
        idx <= '0;
        dx <= '0;
        dy <= '0;
      end
      if (pass) begin
        if (step) begin
          dx <= '0;
          dy <= '0;
          idx <= last_spr ? '0 : idx + 1'b1;
          if (!erasing) begin
            last_x[idx] <= px_s[idx];
            last_y[idx] <= py_s[idx];
            last_valid[idx] <= en_s[idx];
          end
        end else begin
          dx <= last_col ? '0 : dx + 1'b1;
          dy <= last_col ? dy + 1'b1 : dy;
        end
      end
    end
  end
endmodule

// File: tb/tb_sprite_plotter.sv
// tb_sprite_plotter: directed frame-sequence checks of sprite_plotter pixel streams and handshakes
module tb_sprite_plotter;
  logic clock = 1'b0, resetn = 1'b0, tick = 1'b0;
  logic [15:0] pos_x = '0;
  logic [13:0] pos_y = '0;
  logic [5:0] colour = '0;
  logic [1:0] enable = '0;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic plot, busy, done, overrun;
  int tests = 0, fails = 0, done_cnt = 0;
  logic [17:0] got_q [$];
  logic [17:0] exp_q [$];
  sprite_plotter dut (
    .clock(clock), .resetn(resetn), .tick(tick), .pos_x(pos_x), .pos_y(pos_y),
    .colour(colour), .enable(enable), .out_x(out_x), .out_y(out_y),
    .out_colour(out_colour), .plot(plot), .busy(busy), .done(done), .overrun(overrun)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (plot) got_q.push_back({out_x, out_y, out_colour});
    if (done) done_cnt++;
  end
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task add_rect(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 2; i++)
        exp_q.push_back({8'(x + i), 7'(y + j), c});
  endtask
  task launch(input logic [7:0] x0, input logic [6:0] y0, input logic [7:0] x1,
              input logic [6:0] y1, input logic [1:0] en, input bit hold);
    got_q.delete();
    done_cnt = 0;
    @(negedge clock);
    pos_x = {x1, x0};
    pos_y = {y1, y0};
    colour = {3'b101, 3'b110};
    enable = en;
    tick = 1'b1;
    @(negedge clock);
    tick = hold;
    pos_x = 16'($urandom);
    pos_y = 14'($urandom);
    colour = 6'($urandom);
    enable = 2'($urandom);
  endtask
  task finish_frame(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    tick = 1'b0;
    check({tag, " timeout"}, 32'(n < 200), 32'd1);
    repeat (3) @(negedge clock);
    check({tag, " count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("%s px%0d", tag, k), k < got_q.size() ? 32'(got_q[k]) : 32'hffffffff, 32'(exp_q[k]));
    check({tag, " done"}, done_cnt, 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    exp_q.delete();
  endtask
  initial begin
    int n;
    #23;
    check("rst plot", 32'(plot), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst overrun", 32'(overrun), 0);
    check("rst out", {out_x, out_y, out_colour}, 0);
    resetn = 1'b1;
    launch(80, 60, 15, 61, 2'b01, 0);
    add_rect(80, 60, 3'b110);
    finish_frame("first");
    check("first overrun", 32'(overrun), 0);
    launch(81, 60, 15, 61, 2'b01, 0);
    add_rect(80, 60, 3'b000);
    add_rect(81, 60, 3'b110);
    finish_frame("move");
    launch(81, 60, 15, 61, 2'b01, 0);
    add_rect(81, 60, 3'b110);
    finish_frame("still");
    launch(255, 127, 15, 61, 2'b01, 0);
    add_rect(81, 60, 3'b000);
    add_rect(255, 127, 3'b110);
    finish_frame("wrap");
    launch(255, 127, 15, 61, 2'b11, 0);
    add_rect(255, 127, 3'b110);
    add_rect(15, 61, 3'b101);
    finish_frame("both");
    launch(255, 127, 15, 61, 2'b01, 0);
    add_rect(15, 61, 3'b000);
    add_rect(255, 127, 3'b110);
    finish_frame("hide1");
    launch(255, 127, 15, 61, 2'b01, 0);
    add_rect(255, 127, 3'b110);
    finish_frame("hidden");
    check("pre overrun", 32'(overrun), 0);
    launch(10, 20, 15, 61, 2'b01, 1);
    add_rect(255, 127, 3'b000);
    add_rect(10, 20, 3'b110);
    finish_frame("spam");
    check("spam overrun", 32'(overrun), 1);
    launch(30, 40, 15, 61, 2'b01, 0);
    n = 0;
    while (got_q.size() < 5 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("middraw reached", 32'(n < 200), 1);
    #2 resetn = 1'b0;
    #1;
    check("arst plot", 32'(plot), 0);
    check("arst busy", 32'(busy), 0);
    check("arst done", 32'(done), 0);
    check("arst overrun", 32'(overrun), 0);
    @(negedge clock);
    resetn = 1'b1;
    launch(30, 40, 15, 61, 2'b01, 0);
    add_rect(30, 40, 3'b110);
    finish_frame("after rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
